// File: rtl/mul_arb2.sv
// Two-requester arbitrated multiplier: grants one operand pair at a time, multiplies
// it in a dedicated cycle and holds the product until the consumer takes it.
module mul_arb2 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_data,
  input  logic           rsp_ready,
  output logic           busy,
  output logic [1:0]     dbg_state,
  output logic           dbg_prio
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both high.
  // Requesters hold valid/operands until ready; the consumer sees rsp_valid held with
  // stable data until it samples rsp_ready high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q;
  logic             id_q;
  logic [W-1:0]     a_q, b_q;
  logic [2*W-1:0]   prod_q;
  logic             gnt1;
  logic             hs;

  // Requester 1 wins when it is alone, or when both contend and prio points at it.
  assign gnt1 = req1_valid && (!req0_valid || prio_q);

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            req0_ready = !gnt1;
            req1_ready = gnt1;
            state_d    = MUL;
          end
        end
        MUL:     state_d = RESP;
        RESP:    if (rsp_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign hs = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        a_q    <= gnt1 ? req1_a : req0_a;
        b_q    <= gnt1 ? req1_b : req0_b;
        id_q   <= gnt1;
        prio_q <= !gnt1;
      end
      // Zero-extend first so the product keeps all 2*W bits.
      if (state_q == MUL) begin
        prod_q <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = prod_q;
  assign busy      = (state_q != IDLE) && !rst;
  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

endmodule

// File: tb/tb_mul_arb2.sv
// Bench for mul_arb2: queue-driven requesters, a transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed results.
module tb_mul_arb2;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           rsp_valid, rsp_id, rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic           busy;
  logic [1:0]     dbg_state;
  logic           dbg_prio;

  always #5 clk = ~clk;

  mul_arb2 #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .dbg_state(dbg_state), .dbg_prio(dbg_prio)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requester operand queues, next-cycle controls and logs.
  logic [W-1:0] q0_a[$], q0_b[$], q1_a[$], q1_b[$];
  logic         rst_nxt, rsp_ready_nxt;
  logic         hs0, hs1;
  int           cyc;
  int           acc_id_q[$], acc_cyc_q[$];
  int           rsp_id_log[$], rsp_data_log[$], rsp_cyc_q[$];

  // Reference model: at most one transaction in flight; it is presented two cycles
  // after acceptance and retires when the consumer takes it.
  logic [2*W:0] exp_q[$];
  bit           m_busy;
  int           m_age;
  bit           m_prio;

  always @(negedge clk) begin : model
    logic         e0, e1, erv;
    logic [2*W-1:0] p;
    if (rst) begin
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_busy", busy, 0);
      m_busy = 0;
      m_age  = 0;
      m_prio = 0;
      exp_q.delete();
    end else begin
      e0  = !m_busy && req0_valid && (!req1_valid || !m_prio);
      e1  = !m_busy && req1_valid && (!req0_valid || m_prio);
      erv = m_busy && (m_age == 2);
      chk("ready0", req0_ready, e0);
      chk("ready1", req1_ready, e1);
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, erv);
      if (erv && exp_q.size() > 0) begin
        chk("rsp_data", rsp_data, exp_q[0][2*W-1:0]);
        chk("rsp_id", rsp_id, exp_q[0][2*W]);
      end
      if (e0 || e1) begin
        p = e1 ? ({{W{1'b0}}, req1_a} * {{W{1'b0}}, req1_b})
               : ({{W{1'b0}}, req0_a} * {{W{1'b0}}, req0_b});
        exp_q.push_back({e1, p});
        m_busy = 1;
        m_age  = 1;
        m_prio = !e1;
      end else if (m_busy) begin
        if (m_age == 1) m_age = 2;
        else if (rsp_ready) begin
          m_busy = 0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock: apply inputs just after posedge, then sample at the negedge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst       = rst_nxt;
    rsp_ready = rsp_ready_nxt;
    if (hs0) begin void'(q0_a.pop_front()); void'(q0_b.pop_front()); end
    if (hs1) begin void'(q1_a.pop_front()); void'(q1_b.pop_front()); end
    if (q0_a.size() > 0) begin
      req0_valid = 1'b1; req0_a = q0_a[0]; req0_b = q0_b[0];
    end else begin
      req0_valid = 1'b0; req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
    end
    if (q1_a.size() > 0) begin
      req1_valid = 1'b1; req1_a = q1_a[0]; req1_b = q1_b[0];
    end else begin
      req1_valid = 1'b0; req1_a = W'($urandom_range(0, 15)); req1_b = W'($urandom_range(0, 15));
    end
    @(negedge clk);
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (hs0) begin acc_id_q.push_back(0); acc_cyc_q.push_back(cyc); end
    if (hs1) begin acc_id_q.push_back(1); acc_cyc_q.push_back(cyc); end
    if (rsp_valid && rsp_ready) begin
      rsp_id_log.push_back(int'(rsp_id));
      rsp_data_log.push_back(int'(rsp_data));
      rsp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    acc_id_q.delete(); acc_cyc_q.delete();
    rsp_id_log.delete(); rsp_data_log.delete(); rsp_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst_nxt = 1'b1;
    step();
    step();
    rst_nxt = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic wait_rsp(input int n, input int max_cyc);
    int k = 0;
    while (rsp_data_log.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    chk("rsp_count", rsp_data_log.size(), n);
  endtask

  task automatic push0(input int a, input int b);
    q0_a.push_back(W'(a)); q0_b.push_back(W'(b));
  endtask

  task automatic push1(input int a, input int b);
    q1_a.push_back(W'(a)); q1_b.push_back(W'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ids[6]  = '{0, 1, 0, 1, 0, 1};
    int exp_prod[6] = '{2, 6, 0, 0, 225, 16};
    int k;
    rst = 1'b1; rst_nxt = 1'b1;
    rsp_ready = 1'b1; rsp_ready_nxt = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    hs0 = 1'b0; hs1 = 1'b0; cyc = 0;

    // Reset state
    do_reset();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_busy", busy, 0);
    chk("reset_prio", dbg_prio, 0);

    // Single request 3*5
    push0(3, 5);
    wait_rsp(1, 20);
    if (rsp_data_log.size() >= 1 && acc_cyc_q.size() >= 1) begin
      chk("single_grant_id", acc_id_q[0], 0);
      chk("single_data", rsp_data_log[0], 15);
      chk("single_id", rsp_id_log[0], 0);
      chk("single_latency", rsp_cyc_q[0] - acc_cyc_q[0], 2);
    end

    // Contention right after reset: req0 first, then req1
    do_reset();
    push0(7, 9);
    push1(15, 15);
    wait_rsp(2, 30);
    if (rsp_data_log.size() >= 2 && acc_cyc_q.size() >= 2) begin
      chk("cont_data0", rsp_data_log[0], 63);
      chk("cont_id0", rsp_id_log[0], 0);
      chk("cont_data1", rsp_data_log[1], 225);
      chk("cont_id1", rsp_id_log[1], 1);
      chk("cont_interval", acc_cyc_q[1] - acc_cyc_q[0], 3);
    end

    // Continuous contention, six transactions, including 0*15, 15*0 and 15*15
    do_reset();
    push0(1, 2);  push0(0, 15); push0(15, 15);
    push1(2, 3);  push1(15, 0); push1(4, 4);
    wait_rsp(6, 60);
    if (rsp_data_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("alt_id%0d", i), rsp_id_log[i], exp_ids[i]);
        chk($sformatf("alt_data%0d", i), rsp_data_log[i], exp_prod[i]);
      end
    end

    // Backpressure: hold the response for several cycles with a request waiting
    clear_logs();
    rsp_ready_nxt = 1'b0;
    push0(6, 7);
    push1(3, 3);
    k = 0;
    step();
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    chk("bp_seen", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 42);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      step();
    end
    rsp_ready_nxt = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 1);
    chk("bp_release_data", rsp_data, 42);
    step();
    chk("bp_idle_valid", rsp_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_idle_ready1", req1_ready, 1);
    wait_rsp(2, 20);
    if (rsp_data_log.size() >= 2) begin
      chk("bp_next_data", rsp_data_log[1], 9);
      chk("bp_next_id", rsp_id_log[1], 1);
    end

    // Reset while a multiply is in flight
    clear_logs();
    push0(5, 5);
    k = 0;
    while (acc_id_q.size() < 1 && k < 20) begin
      step();
      k++;
    end
    chk("mid_accepted", acc_id_q.size(), 1);
    rst_nxt = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready0", req0_ready, 0);
    rst_nxt = 1'b0;
    step();
    chk("mid_after_busy", busy, 0);
    chk("mid_after_valid", rsp_valid, 0);
    chk("mid_after_data", rsp_data, 0);
    chk("mid_after_id", rsp_id, 0);
    chk("mid_after_prio", dbg_prio, 0);
    repeat (6) step();
    chk("mid_no_spurious", rsp_data_log.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_arb2.md
MUL_ARB2 -- requirements
Module: mul_arb2

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits; the product is 2*W bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 has an operand pair pending.
REQ-005 SHALL have port req0_a, input, W, requester 0 multiplicand (unsigned).
REQ-006 SHALL have port req0_b, input, W, requester 0 multiplier (unsigned).
REQ-007 SHALL have port req0_ready, output, 1, requester 0 operands accepted this cycle.
REQ-008 SHALL have ports req1_valid, req1_a, req1_b and req1_ready, identical in direction, width and meaning to REQ-004..REQ-007, for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1, a result is presented.
REQ-010 SHALL have port rsp_id, output, 1, the index of the requester that owns the result.
REQ-011 SHALL have port rsp_data, output, 2*W, the unsigned product a*b.
REQ-012 SHALL have port rsp_ready, input, 1, the consumer accepts the result.
REQ-013 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, MUL and RESP.
REQ-015 In IDLE, the block SHALL form the grant combinationally: if only one reqN_valid is high, grant that requester; if both are high, grant the requester selected by the priority bit prio.
REQ-016 reqN_ready SHALL be driven combinationally high only in IDLE and only for the granted requester; at most one reqN_ready SHALL be high in any cycle.
REQ-017 On handshake (reqN_valid & reqN_ready), the block SHALL register the operands and the id, set prio to the other requester, and move to MUL.
REQ-018 In MUL, the block SHALL register the full-width unsigned product of the captured operands, with no truncation (for W=4, 15*15=225), and move to RESP.
REQ-019 In RESP, rsp_valid SHALL be 1; rsp_data and rsp_id SHALL hold stable until rsp_ready is sampled high.
REQ-020 On rsp_valid & rsp_ready, the block SHALL drop rsp_valid next cycle and return to IDLE.
REQ-021 Latency SHALL be exactly 2 cycles: rsp_valid rises on the 2nd posedge after the accepting edge.
REQ-022 Minimum issue interval SHALL be 3 cycles; no request SHALL be accepted in MUL or RESP.
REQ-023 A requester SHALL hold valid/a/b stable until ready; deasserting valid before ready SHALL cancel the request with no state change.
REQ-024 The two requests SHALL alternate grants under continuous contention, so that no requester waits more than one full transaction.
REQ-025 Operand changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-026 With rst high at a posedge, the block SHALL set state=IDLE, prio=0, rsp_valid=0, rsp_id=0 and rsp_data=0, and clear the captured operands.
REQ-027 Reset SHALL take precedence over every other event; asserting it in MUL or RESP SHALL discard the in-flight result with no rsp_valid after release.
REQ-028 While rst is high, req0_ready and req1_ready SHALL be 0 and busy SHALL be 0.

Verification
REQ-029 Bench SHALL cover a single request: req0 a=3, b=5, rsp_ready=1 -> req0_ready 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=15.
REQ-030 Bench SHALL cover contention after reset: both valid, req0 7*9, req1 15*15 -> req0 is granted first (rsp 63, id 0), then req1 (rsp 225, id 1).
REQ-031 Bench SHALL cover continuous contention for 6 transactions -> grant ids 0,1,0,1,0,1.
REQ-032 Bench SHALL cover backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant, req ready stays 0; rsp_ready=1 -> IDLE next cycle.
REQ-033 Bench SHALL cover reset mid-operation: rst asserted in MUL -> next cycle state IDLE, rsp_valid=0, rsp_data=0, prio=0, with no spurious response.
REQ-034 Bench SHALL cover boundaries: 0*15 -> 0; 15*15 -> 225; operands changed the cycle after acceptance -> original product returned.
